// File: rtl/unit_cmd_tx_if.sv
// Command and fibre-line signals between the valve-control logic and one unit_cmd_tx.
// The master side drives commands; the transmitter takes the slave side.
interface unit_cmd_tx_if;
  logic       tx_en;
  logic       start_stop;
  logic [1:0] igbt_control;
  logic       byp_con;
  logic       reset_unit;
  logic       comm_t;
  logic       frame_start;
  logic       busy;
  logic [3:0] seq;

  modport master (
    output tx_en, start_stop, igbt_control, byp_con, reset_unit,
    input  comm_t, frame_start, busy, seq
  );

  modport slave (
    input  tx_en, start_stop, igbt_control, byp_con, reset_unit,
    output comm_t, frame_start, busy, seq
  );
endinterface

// File: rtl/unit_cmd_tx.sv
// Fibre command transmitter for one power-unit COMM_R input: keep-alive and change-triggered frames.
// Define CMD_TX_CRC8_EN for a CRC-8 check byte; otherwise a single even-parity bit is sent.
//
// state  | meaning
// S_IDLE | line high, waiting for a period or command-change trigger while tx_en=1
// S_SEND | shifting start bit, D[15:0], check field and stop bit, BIT_DIV cycles each
// S_GAP  | line held high for GAP_BITS bit times before the next launch is allowed
module unit_cmd_tx #(
  parameter int BIT_DIV      = 20,
  parameter int FRAME_PERIOD = 4000,
  parameter int GAP_BITS     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  unit_cmd_tx_if.slave cmd
);

`ifdef CMD_TX_CRC8_EN
  localparam int CHK_BITS = 8;
`else
  localparam int CHK_BITS = 1;
`endif
  localparam int FRAME_BITS = 18 + CHK_BITS;
  localparam int GAP_CYC    = GAP_BITS * BIT_DIV;
  localparam int TMR_MAX    = (GAP_CYC > BIT_DIV) ? GAP_CYC : BIT_DIV;
  localparam int TMR_W      = $clog2(TMR_MAX);
  localparam int PER_W      = $clog2(FRAME_PERIOD);
  localparam int IDX_W      = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [PER_W-1:0]      per_q;
  logic [3:0]            seq_q;
  logic                  rst_lat_q;
  logic [3:0]            snap_q;

  logic [3:0]  live;
  logic [15:0] data_word;
  logic        per_done, tmr_done, last_bit, trigger, launch;
  logic        comm_t_c, frame_start_c, busy_c;

`ifdef CMD_TX_CRC8_EN
  function automatic logic [7:0] chk_field(input logic [15:0] d);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      crc = (crc[7] ^ d[i]) ? ({crc[6:0], 1'b0} ^ 8'h07) : {crc[6:0], 1'b0};
    end
    return crc;
  endfunction
`else
  function automatic logic [0:0] chk_field(input logic [15:0] d);
    return ^d;
  endfunction
`endif

  assign live      = {cmd.start_stop, cmd.igbt_control, cmd.byp_con};
  assign data_word = {4'b1010, seq_q, live, rst_lat_q, 3'b000};
  assign per_done  = (per_q == '0);
  assign tmr_done  = (tmr_q == '0);
  assign last_bit  = (bit_idx_q == '0);
  // reset_unit is deliberately not part of the change compare
  assign trigger   = cmd.tx_en && (per_done || (live != snap_q));
  assign launch    = (state_q == S_IDLE) && trigger;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trigger) state_d = S_SEND;
      S_SEND:  if (tmr_done && last_bit) state_d = S_GAP;
      S_GAP:   if (tmr_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    comm_t_c      = 1'b1;
    frame_start_c = 1'b0;
    busy_c        = 1'b0;
    case (state_q)
      S_SEND: begin
        comm_t_c      = frame_q[FRAME_BITS-1];
        busy_c        = 1'b1;
        frame_start_c = (bit_idx_q == IDX_W'(FRAME_BITS - 1)) && (tmr_q == TMR_W'(BIT_DIV - 1));
      end
      S_GAP:   busy_c = 1'b1;
      default: ;
    endcase
  end

  assign cmd.comm_t      = comm_t_c;
  assign cmd.frame_start = frame_start_c;
  assign cmd.busy        = busy_c;
  assign cmd.seq         = seq_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '1;
      per_q     <= '0;
      seq_q     <= '0;
      rst_lat_q <= 1'b0;
      snap_q    <= '0;
    end else begin
      // an expired period stays at zero until the next launch consumes it
      if (launch)         per_q <= PER_W'(FRAME_PERIOD - 1);
      else if (!per_done) per_q <= per_q - PER_W'(1);

      // a pulse on the launch cycle wins, so it rides in the following frame
      if (cmd.reset_unit) rst_lat_q <= 1'b1;
      else if (launch)    rst_lat_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (launch) begin
            frame_q   <= {1'b0, data_word, chk_field(data_word), 1'b1};
            snap_q    <= live;
            tmr_q     <= TMR_W'(BIT_DIV - 1);
            bit_idx_q <= IDX_W'(FRAME_BITS - 1);
          end
        end
        S_SEND: begin
          if (!tmr_done) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end else if (last_bit) begin
            tmr_q <= TMR_W'(GAP_CYC - 1);
            seq_q <= seq_q + 4'd1;
          end else begin
            frame_q   <= {frame_q[FRAME_BITS-2:0], 1'b1};
            bit_idx_q <= bit_idx_q - IDX_W'(1);
            tmr_q     <= TMR_W'(BIT_DIV - 1);
          end
        end
        S_GAP: begin
          if (!tmr_done) tmr_q <= tmr_q - TMR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_cmd_tx.sv
// Bench for unit_cmd_tx: directed scenarios plus random commands against a cycle-level frame model.
// Follows CMD_TX_CRC8_EN to select the expected check field.
module tb_unit_cmd_tx;
  localparam int BIT_DIV      = 4;
  localparam int FRAME_PERIOD = 200;
  localparam int GAP_BITS     = 2;
`ifdef CMD_TX_CRC8_EN
  localparam int FB = 26;
  localparam logic [FB-1:0] EXP_FIRST = {1'b0, 16'hA0C0, 8'h56, 1'b1};
`else
  localparam int FB = 19;
  localparam logic [FB-1:0] EXP_FIRST = {1'b0, 16'hA0C0, 1'b0, 1'b1};
`endif
  localparam int FRAME_CYC = FB * BIT_DIV;
  localparam int BUSY_CYC  = FRAME_CYC + GAP_BITS * BIT_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tcyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  unit_cmd_tx_if cmd_if();

  unit_cmd_tx #(
    .BIT_DIV(BIT_DIV), .FRAME_PERIOD(FRAME_PERIOD), .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, tcyc);
    end
  endtask

  // check field by long division of D*x^8 by x^8+x^2+x+1
  function automatic logic [FB-1:0] build_frame(input logic [15:0] d);
`ifdef CMD_TX_CRC8_EN
    logic [23:0] rem;
    rem = {d, 8'h00};
    for (int i = 23; i >= 8; i--) if (rem[i]) rem = rem ^ (24'h107 << (i - 8));
    return {1'b0, d, rem[7:0], 1'b1};
`else
    int ones;
    ones = 0;
    for (int i = 0; i < 16; i++) ones += d[i];
    return {1'b0, d, 1'(ones % 2), 1'b1};
`endif
  endfunction

  // reference model: last launch cycle, expected frame, seq, reset latch, command snapshot
  int             last_fs = -100000;
  logic [FB-1:0]  exp_frame = '1;
  logic [3:0]     m_seq = '0;
  logic           m_lat = 1'b0;
  logic [3:0]     m_snap = '0;
  bit             model_ok = 1'b0;

  always @(negedge clk) begin
    int k;
    logic [3:0] live;
    logic exp_comm, go;
    k = tcyc - last_fs;
    if (model_ok) begin
      exp_comm = (k >= 0 && k < FRAME_CYC) ? exp_frame[FB - 1 - k / BIT_DIV] : 1'b1;
      check_val("comm_t", cmd_if.comm_t, exp_comm);
      check_val("frame_start", cmd_if.frame_start, k == 0);
      check_val("busy", cmd_if.busy, k >= 0 && k < BUSY_CYC);
      check_val("seq", cmd_if.seq, m_seq);
    end
    if (!rst_n) begin
      last_fs  = -100000;
      m_seq    = '0;
      m_lat    = 1'b0;
      m_snap   = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      live = {cmd_if.start_stop, cmd_if.igbt_control, cmd_if.byp_con};
      if (k == FRAME_CYC - 1) m_seq = m_seq + 4'd1;
      go = cmd_if.tx_en && (k >= BUSY_CYC) &&
           ((tcyc + 1 - last_fs >= FRAME_PERIOD) || (live != m_snap));
      if (go) begin
        exp_frame = build_frame({4'hA, m_seq, live, m_lat, 3'b000});
        m_snap    = live;
        last_fs   = tcyc + 1;
      end
      if (cmd_if.reset_unit) m_lat = 1'b1;
      else if (go)           m_lat = 1'b0;
    end
  end

  task automatic wait_fs(input int budget, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_if.frame_start && n < budget);
    if (!cmd_if.frame_start) check_val("fs_timeout", 0, 1);
    at = tcyc;
  endtask

  initial begin
    int prev, at, nfs;
    logic [FB-1:0] word;
    logic b6, b5;
    cmd_if.tx_en        = 1'b1;
    cmd_if.start_stop   = 1'b1;
    cmd_if.igbt_control = 2'b10;
    cmd_if.byp_con      = 1'b0;
    cmd_if.reset_unit   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // first frame right after reset release
    @(negedge clk);
    check_val("fs_not_yet", cmd_if.frame_start, 0);
    @(negedge clk);
    check_val("fs_first", cmd_if.frame_start, 1);
    prev = tcyc;
    word = '0;
    for (int i = 0; i < FB; i++) begin
      repeat ((i == 0) ? 1 : BIT_DIV) @(negedge clk);
      word = {word[FB-2:0], cmd_if.comm_t};
    end
    check_val("first_frame", word, EXP_FIRST);

    // keep-alive period and seq wrap
    for (int i = 0; i < 17; i++) begin
      wait_fs(FRAME_PERIOD + 100, at);
      check_val("period", at - prev, FRAME_PERIOD);
      check_val("seq_at_fs", cmd_if.seq, (i + 1) % 16);
      prev = at;
    end

    // command change mid-frame launches right after the gap
    repeat (10) @(posedge clk);
    #1 cmd_if.igbt_control = 2'b01;
    wait_fs(FRAME_PERIOD + 100, at);
    check_val("change_latency", at - prev, BUSY_CYC + 1);
    repeat (41) @(negedge clk);
    b6 = cmd_if.comm_t;
    repeat (4) @(negedge clk);
    b5 = cmd_if.comm_t;
    check_val("igbt_new", {b6, b5}, 2'b01);

    // fault-reset pulse rides in exactly one frame
    wait_fs(FRAME_PERIOD + 100, at);
    repeat (30) @(posedge clk);
    #1 cmd_if.reset_unit = 1'b1;
    @(posedge clk);
    #1 cmd_if.reset_unit = 1'b0;
    wait_fs(FRAME_PERIOD + 100, at);
    repeat (53) @(negedge clk);
    check_val("rst_bit_set", cmd_if.comm_t, 1);
    wait_fs(FRAME_PERIOD + 100, at);
    repeat (53) @(negedge clk);
    check_val("rst_bit_clr", cmd_if.comm_t, 0);

    // tx_en dropped mid-frame
    wait_fs(FRAME_PERIOD + 100, at);
    repeat (20) @(posedge clk);
    #1 cmd_if.tx_en = 1'b0;
    nfs = 0;
    repeat (300) begin
      @(negedge clk);
      nfs += cmd_if.frame_start;
    end
    check_val("no_fs_txen0", nfs, 0);
    check_val("idle_line", cmd_if.comm_t, 1);
    check_val("idle_busy", cmd_if.busy, 0);
    @(posedge clk);
    #1 cmd_if.tx_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("fs_txen_resume", cmd_if.frame_start, 1);

    // reset mid-frame
    wait_fs(FRAME_PERIOD + 100, at);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_comm_t", cmd_if.comm_t, 1);
    check_val("rst_busy", cmd_if.busy, 0);
    check_val("rst_seq", cmd_if.seq, 0);

    // random commands, pulses, enables and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(999) >= 2);
      cmd_if.reset_unit = ($urandom_range(99) < 2);
      if ($urandom_range(99) < 3) begin
        cmd_if.start_stop   = 1'($urandom);
        cmd_if.igbt_control = 2'($urandom);
        cmd_if.byp_con      = 1'($urandom);
      end
      if ($urandom_range(199) == 0) cmd_if.tx_en = ~cmd_if.tx_en;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmd_if.reset_unit = 1'b0;
    cmd_if.tx_en = 1'b1;
    repeat (400) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
